// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the memory port arbiter: core port, debug port, memory port, lock status.
// Pure wiring, no latency of its own.
// Requesters hold req with address/data stable until gnt; the memory side never stalls.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              locked;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output locked
  );

  // Requester and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  locked
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between the core port and the debug/loader port, with debug bus lock.
// Grant is combinational in the request cycle; writes commit at its closing edge, read data returns one cycle later.
// A requester not granted simply keeps req asserted; a starvation limit bounds how long either one waits.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int CPU_PRIO     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  lock_state_e       lock_q, lock_d;
  owner_e            last_q, last_d;
  owner_e            owner_c;
  logic [7:0]        starve_q, starve_d;
  logic              cpu_gnt_c, dbg_gnt_c, contested;
  logic              cpu_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              mem_we_c;

  // Pick at most one owner for this cycle; reset forces both grants off
  always_comb begin
    cpu_gnt_c = 1'b0;
    dbg_gnt_c = 1'b0;
    contested = bus.cpu_req && bus.dbg_req && (lock_q == ST_OPEN);
    if (!reset_n) begin
      cpu_gnt_c = 1'b0;
      dbg_gnt_c = 1'b0;
    end else if (lock_q == ST_LOCKED) begin
      // The core is shut out for the whole lock, even when debug is idle
      dbg_gnt_c = bus.dbg_req;
    end else if (contested) begin
      if (starve_q >= LIMIT) begin
        if (last_q == OWN_CPU) dbg_gnt_c = 1'b1;
        else                   cpu_gnt_c = 1'b1;
      end else if (CPU_PRIO != 0) begin
        cpu_gnt_c = 1'b1;
      end else begin
        dbg_gnt_c = 1'b1;
      end
    end else begin
      cpu_gnt_c = bus.cpu_req;
      dbg_gnt_c = bus.dbg_req;
    end
  end

  // Route the owner's request to memory; the core address is parked there when idle
  always_comb begin
    mem_addr_c  = bus.cpu_addr;
    mem_wdata_c = bus.cpu_wdata;
    if (dbg_gnt_c) begin
      mem_addr_c  = bus.dbg_addr;
      mem_wdata_c = bus.dbg_wdata;
    end
    mem_we_c = (cpu_gnt_c && bus.cpu_we) || (dbg_gnt_c && bus.dbg_we);
  end

  // Track consecutive contested wins by the same owner; any other cycle clears the run
  always_comb begin
    starve_d = 8'd0;
    last_d   = last_q;
    owner_c  = dbg_gnt_c ? OWN_DBG : OWN_CPU;
    if (cpu_gnt_c || dbg_gnt_c) begin
      last_d = owner_c;
      if (contested) begin
        if (owner_c == last_q) starve_d = (starve_q == 8'hFF) ? starve_q : starve_q + 8'd1;
        else                   starve_d = 8'd1;
      end
    end
  end

  // Lock is taken by a debug grant with dbg_lock and dropped as soon as dbg_lock falls
  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      ST_OPEN:   if (dbg_gnt_c && bus.dbg_lock) lock_d = ST_LOCKED;
      ST_LOCKED: if (!bus.dbg_lock)             lock_d = ST_OPEN;
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q   <= ST_OPEN;
      last_q   <= OWN_CPU;
      starve_q <= 8'd0;
    end else begin
      lock_q   <= lock_d;
      last_q   <= last_d;
      starve_q <= starve_d;
    end
  end

  // Capture read data for the granted reader; rdata holds until that port reads again
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_gnt_c && !bus.cpu_we;
      dbg_rvalid_q <= dbg_gnt_c && !bus.dbg_we;
      if (cpu_gnt_c && !bus.cpu_we) cpu_rdata_q <= bus.mem_rdata;
      if (dbg_gnt_c && !bus.dbg_we) dbg_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_c;
  assign bus.dbg_gnt    = dbg_gnt_c;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.locked     = (lock_q == ST_LOCKED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run against a reference model.
// Memory is a 64-word array with combinational read and rising-edge write.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int CPU_PRIO     = 1;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPU_PRIO(CPU_PRIO), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory seen by the arbiter
  logic [31:0] mem [0:63];
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

  // Reference model state
  logic [31:0] ref_mem [0:63];
  logic        m_locked, m_crv, m_drv;
  logic [31:0] m_crd, m_drd;
  int          last_owner;   // 0 core, 1 debug
  int          chist[$];     // winners of the current unbroken run of contested cycles

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic cr, input logic cwe, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dwe, input logic dl, input logic [31:0] da,
                       input logic [31:0] dd);
    bus.cpu_req = cr; bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dbg_req = dr; bus.dbg_we = dwe; bus.dbg_lock = dl; bus.dbg_addr = da; bus.dbg_wdata = dd;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
  endtask

  // Debug-port write used as a program loader; mirrors into the reference memory
  task automatic load_word(input logic [31:0] a, input logic [31:0] v);
    drive(0, 0, 32'h0, 32'h0, 1, 1, 0, a, v);
    ref_mem[a[7:2]] = v;
    next_cycle();
    idle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1, 1, 32'h8, 32'h1, 1, 1, 0, 32'hC, 32'h2);
    #2;
    total++; if ({bus.cpu_gnt, bus.dbg_gnt, bus.mem_we} !== 3'b000) begin
      bad++; $display("FAIL reset_gnt got=%b exp=000", {bus.cpu_gnt, bus.dbg_gnt, bus.mem_we}); end
    total++; if ({bus.cpu_rvalid, bus.dbg_rvalid, bus.locked} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {bus.cpu_rvalid, bus.dbg_rvalid, bus.locked}); end
    total++; if ({bus.cpu_rdata, bus.dbg_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.cpu_rdata, bus.dbg_rdata); end
    total++; if (bus.mem_addr !== 32'h8) begin
      bad++; $display("FAIL reset_mem_addr got=%h exp=00000008", bus.mem_addr); end
    do_reset();
  endtask

  task automatic test_core_reads();
    drive(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    total++; if ({bus.cpu_gnt, bus.cpu_rvalid} !== 2'b10) begin
      bad++; $display("FAIL core_rd_c1 gnt/rvalid got=%b exp=10", {bus.cpu_gnt, bus.cpu_rvalid}); end
    next_cycle();
    drive(1, 0, 32'h4, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    total++; if ({bus.cpu_gnt, bus.cpu_rvalid, bus.cpu_rdata} !== {2'b11, 32'h00500113}) begin
      bad++; $display("FAIL core_rd_c2 got=%b%b %h exp=11 00500113", bus.cpu_gnt, bus.cpu_rvalid, bus.cpu_rdata); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if ({bus.cpu_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata} !== {3'b010, 32'h00C00193}) begin
      bad++; $display("FAIL core_rd_c3 got=%b%b%b %h exp=010 00c00193",
                      bus.cpu_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata); end
    next_cycle();
    @(negedge clk);
    total++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 32'h00C00193}) begin
      bad++; $display("FAIL core_rd_hold got=%b %h exp=0 00c00193", bus.cpu_rvalid, bus.cpu_rdata); end
    next_cycle();
  endtask

  task automatic test_dbg_write_read();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    total++; if ({bus.dbg_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 32'h40, 32'hDEADBEEF}) begin
      bad++; $display("FAIL dbg_wr got=%b%b %h %h exp=11 00000040 deadbeef",
                      bus.dbg_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    next_cycle();
    drive(1, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    total++; if ({bus.cpu_gnt, bus.dbg_gnt, bus.mem_we, bus.dbg_rvalid} !== 4'b1000) begin
      bad++; $display("FAIL dbg_wr_then_rd got=%b exp=1000",
                      {bus.cpu_gnt, bus.dbg_gnt, bus.mem_we, bus.dbg_rvalid}); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if ({bus.cpu_rvalid, bus.mem_we, bus.cpu_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      bad++; $display("FAIL dbg_wr_readback got=%b%b %h exp=10 deadbeef", bus.cpu_rvalid, bus.mem_we, bus.cpu_rdata); end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic [9:0] exp_dbg;
    exp_dbg = 10'b10_0001_0000;   // pattern C,C,C,C,D,C,C,C,C,D (bit i = cycle i)
    do_reset();
    drive(1, 0, 32'h0, 32'h0, 1, 0, 0, 32'h4, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if ({bus.cpu_gnt, bus.dbg_gnt} !== {~exp_dbg[i], exp_dbg[i]}) begin
        bad++; $display("FAIL starve_cycle%0d cpu/dbg gnt got=%b%b exp=%b%b",
                        i, bus.cpu_gnt, bus.dbg_gnt, ~exp_dbg[i], exp_dbg[i]); end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_lock();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h10, 32'h0);
    @(negedge clk);
    total++; if ({bus.dbg_gnt, bus.locked} !== 2'b10) begin
      bad++; $display("FAIL lock_take got=%b exp=10", {bus.dbg_gnt, bus.locked}); end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h4, 32'h0, 0, 0, 1, 32'h0, 32'h0);
      @(negedge clk);
      total++; if ({bus.cpu_gnt, bus.dbg_gnt, bus.locked} !== 3'b001) begin
        bad++; $display("FAIL lock_hold%0d got=%b exp=001", i, {bus.cpu_gnt, bus.dbg_gnt, bus.locked}); end
      if (i == 0) begin
        total++; if ({bus.dbg_rvalid, bus.dbg_rdata} !== {1'b1, 32'h12345678}) begin
          bad++; $display("FAIL lock_rdata got=%b %h exp=1 12345678", bus.dbg_rvalid, bus.dbg_rdata); end
      end
      next_cycle();
    end
    drive(1, 0, 32'h4, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    total++; if ({bus.cpu_gnt, bus.locked} !== 2'b01) begin
      bad++; $display("FAIL lock_release_cycle got=%b exp=01", {bus.cpu_gnt, bus.locked}); end
    next_cycle();
    @(negedge clk);
    total++; if ({bus.cpu_gnt, bus.locked} !== 2'b10) begin
      bad++; $display("FAIL lock_after got=%b exp=10", {bus.cpu_gnt, bus.locked}); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 32'h00C00193}) begin
      bad++; $display("FAIL lock_cpu_rd got=%b %h exp=1 00c00193", bus.cpu_rvalid, bus.cpu_rdata); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 32'h4, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    total++; if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b10) begin
      bad++; $display("FAIL b2b_c0 got=%b exp=10", {bus.cpu_gnt, bus.dbg_gnt}); end
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h40, 32'h0);
    @(negedge clk);
    total++; if ({bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata} !== {3'b110, 32'h00C00193}) begin
      bad++; $display("FAIL b2b_c1 got=%b%b%b %h exp=110 00c00193",
                      bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata); end
    next_cycle();
    drive(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    total++; if ({bus.cpu_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.dbg_rdata, bus.cpu_rdata}
                 !== {3'b101, 32'hDEADBEEF, 32'h00C00193}) begin
      bad++; $display("FAIL b2b_c2 got=%b%b%b %h %h exp=101 deadbeef 00c00193",
                      bus.cpu_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.dbg_rdata, bus.cpu_rdata); end
    next_cycle();
    drive(1, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    total++; if ({bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata, bus.dbg_rdata}
                 !== {2'b10, 32'h00500113, 32'hDEADBEEF}) begin
      bad++; $display("FAIL b2b_c3 got=%b%b %h %h exp=10 00500113 deadbeef",
                      bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata, bus.dbg_rdata); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      bad++; $display("FAIL b2b_c4 got=%b %h exp=1 deadbeef", bus.cpu_rvalid, bus.cpu_rdata); end
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    drive(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h4, 32'h0);
    next_cycle();
    drive(1, 1, 32'h80, 32'h11111111, 1, 1, 1, 32'h80, 32'h22222222);
    #2;
    total++; if ({bus.cpu_gnt, bus.dbg_gnt, bus.mem_we, bus.dbg_rvalid, bus.locked} !== 5'b01111) begin
      bad++; $display("FAIL rst_mid_before got=%b exp=01111",
                      {bus.cpu_gnt, bus.dbg_gnt, bus.mem_we, bus.dbg_rvalid, bus.locked}); end
    reset_n = 1'b0;
    #1;
    total++; if ({bus.cpu_gnt, bus.dbg_gnt, bus.mem_we} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_gate got=%b exp=000", {bus.cpu_gnt, bus.dbg_gnt, bus.mem_we}); end
    total++; if ({bus.cpu_rvalid, bus.dbg_rvalid, bus.locked} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_flags got=%b exp=000", {bus.cpu_rvalid, bus.dbg_rvalid, bus.locked}); end
    repeat (2) @(posedge clk);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    total++; if ({bus.cpu_rvalid, bus.dbg_rvalid, bus.locked, bus.cpu_rdata, bus.dbg_rdata} !== 67'h0) begin
      bad++; $display("FAIL rst_mid_after got=%b%b%b %h %h exp=000 0 0",
                      bus.cpu_rvalid, bus.dbg_rvalid, bus.locked, bus.cpu_rdata, bus.dbg_rdata); end
    total++; if (mem[32] !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL rst_mid_mem got=%h exp=a5a5a5a5", mem[32]); end
    next_cycle();
  endtask

  task automatic test_random();
    logic        cr, cwe, dr, dwe, dl, ec, ed, ewe;
    logic [31:0] ca, cd, da, dd, eaddr;
    int          run, win;
    for (int k = 0; k < 64; k++) load_word(32'(k * 4), $urandom);
    do_reset();
    m_locked = 0; m_crv = 0; m_drv = 0; m_crd = 0; m_drd = 0;
    last_owner = 0;
    chist.delete();
    for (int i = 0; i < 400; i++) begin
      cr = ($urandom % 4) != 0;  cwe = ($urandom % 3) == 0;
      dr = ($urandom % 4) != 0;  dwe = ($urandom % 3) == 0;
      dl = ($urandom % 8) == 0;
      ca = 32'(($urandom % 64) * 4); cd = $urandom;
      da = 32'(($urandom % 64) * 4); dd = $urandom;
      drive(cr, cwe, ca, cd, dr, dwe, dl, da, dd);
      // Expected owner from the arbitration rules
      ec = 0; ed = 0;
      if (m_locked) begin
        ed = dr;
      end else if (cr && dr) begin
        run = 0;
        for (int k = chist.size() - 1; k >= 0; k--) begin
          if (chist[k] != chist[chist.size() - 1]) break;
          run++;
        end
        if (run > 255) run = 255;
        if (run >= STARVE_LIMIT) win = 1 - last_owner;
        else                     win = (CPU_PRIO != 0) ? 0 : 1;
        ec = (win == 0); ed = (win == 1);
      end else begin
        ec = cr; ed = dr;
      end
      eaddr = ed ? da : ca;
      ewe   = (ec && cwe) || (ed && dwe);
      @(negedge clk);
      total++; if ({bus.cpu_gnt, bus.dbg_gnt, bus.mem_we} !== {ec, ed, ewe}) begin
        bad++; $display("FAIL rnd%0d gnt/we got=%b exp=%b", i, {bus.cpu_gnt, bus.dbg_gnt, bus.mem_we}, {ec, ed, ewe}); end
      total++; if (bus.mem_addr !== eaddr) begin
        bad++; $display("FAIL rnd%0d mem_addr got=%h exp=%h", i, bus.mem_addr, eaddr); end
      if (ewe) begin
        total++; if (bus.mem_wdata !== (ed ? dd : cd)) begin
          bad++; $display("FAIL rnd%0d mem_wdata got=%h exp=%h", i, bus.mem_wdata, ed ? dd : cd); end
      end
      total++; if ({bus.cpu_rvalid, bus.dbg_rvalid, bus.locked} !== {m_crv, m_drv, m_locked}) begin
        bad++; $display("FAIL rnd%0d rvalid/locked got=%b exp=%b", i,
                        {bus.cpu_rvalid, bus.dbg_rvalid, bus.locked}, {m_crv, m_drv, m_locked}); end
      total++; if ({bus.cpu_rdata, bus.dbg_rdata} !== {m_crd, m_drd}) begin
        bad++; $display("FAIL rnd%0d rdata got=%h/%h exp=%h/%h", i, bus.cpu_rdata, bus.dbg_rdata, m_crd, m_drd); end
      // Advance the model across the closing edge
      m_crv = ec && !cwe;
      if (m_crv) m_crd = ref_mem[ca[7:2]];
      m_drv = ed && !dwe;
      if (m_drv) m_drd = ref_mem[da[7:2]];
      if (ec && cwe) ref_mem[ca[7:2]] = cd;
      if (ed && dwe) ref_mem[da[7:2]] = dd;
      if (!m_locked && cr && dr) chist.push_back(ed ? 1 : 0);
      else                       chist.delete();
      if (ec || ed) last_owner = ed ? 1 : 0;
      m_locked = m_locked ? dl : (ed && dl);
      next_cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    load_word(32'h0,  32'h00500113);
    load_word(32'h4,  32'h00C00193);
    load_word(32'h10, 32'h12345678);
    load_word(32'h80, 32'hA5A5A5A5);
    test_core_reads();
    test_dbg_write_read();
    test_starvation();
    test_lock();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified instruction/data memory between two requesters: the multi-cycle core's memory port (fetch and load/store) and a debug/loader port used for program load and memory inspection. The block sits between both requesters and the memory. It grants one access per cycle, returns read data one cycle later, and guarantees the core forward progress through a starvation limit. It also supports a debug lock for atomic multi-word loads.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
CPU_PRIO, 1, 1 = core wins contested cycles by default, 0 = debug wins
STARVE_LIMIT, 4, maximum consecutive contested grants to one requester before the other is forced (range 1..255)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  core access request; held with address/data stable until cpu_gnt
cpu_we  in  1  core write enable
cpu_addr  in  ADDR_W  core address
cpu_wdata  in  DATA_W  core write data
cpu_gnt  out  1  core access performed this cycle
cpu_rvalid  out  1  core read data valid (one cycle after a read grant)
cpu_rdata  out  DATA_W  core read data
dbg_req  in  1  debug access request; same hold rule as core
dbg_we  in  1  debug write enable
dbg_lock  in  1  debug requests exclusive ownership while high
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_gnt  out  1  debug access performed this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DATA_W  debug read data
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable (memory writes on rising edge)
mem_rdata  in  DATA_W  memory combinational read data
locked  out  1  debug currently holds the bus lock

Behaviour:
- Reset (async, reset_n low):
  - cpu_rvalid, dbg_rvalid, locked = 0.
  - cpu_rdata, dbg_rdata = 0.
  - Starvation counter = 0; last-owner = core.
  - While reset is low, the gnt and mem_we outputs are 0 (combinational gating).
- Grant is combinational from req plus registered state. At most one gnt is high per cycle.
  - The granted requester's addr/wdata/we drive mem_*.
  - With no grant: mem_we = 0 and mem_addr = cpu_addr.
- Access timing:
  - Write commits at the rising edge closing the grant cycle.
  - For a read grant in cycle N, mem_rdata is registered into the owner's rdata, and that owner's rvalid = 1 for exactly cycle N+1.
  - rdata holds its value until the next read by that requester.
  - A write grant produces no rvalid.
- Decision order, highest first:
  1. locked = 1: only dbg may be granted; cpu_gnt = 0 even if dbg_req = 0.
  2. Only one req high: that requester is granted.
  3. Both high and the starvation counter has reached STARVE_LIMIT: the requester that was not last-owner is granted.
  4. Both high otherwise: the CPU_PRIO winner is granted.
- Starvation counter (8 bit), updated each cycle:
  - Contested grant to the same owner as last-owner: counter increments, saturating.
  - Contested grant to the other requester: counter = 1 and last-owner updates.
  - Uncontested grant or idle cycle: counter = 0; an uncontested grant still updates last-owner.
  - Cycles while locked = 1: counter = 0.
- Lock state:
  - locked sets at the edge ending a dbg grant cycle with dbg_lock = 1.
  - locked clears at the first edge where dbg_lock = 0, regardless of dbg_req.
  - dbg_lock high without a dbg grant has no effect.
- Simultaneous events:
  - Read grant to one requester in cycle N and grant to the other in N+1: the rvalids are in separate cycles and both rdata registers are independent.
  - A new read grant to the same requester in N+1 updates its rdata at the N+1 edge; rvalid stays high back-to-back.
- Requester that drops req before gnt: no access; no error.
- Reset mid-access: the pending write is not performed, since mem_we is gated by reset_n, and any pending rvalid is lost.

Test Plan:
- Reset, then core-only reads of addr 0x0,0x4 (mem holds 0x00500113,0x00C00193) -> cpu_gnt in cycles 1,2; cpu_rvalid in cycles 2,3 with cpu_rdata 0x00500113 then 0x00C00193; dbg_rvalid stays 0.
- Debug writes 0xDEADBEEF to 0x40, then core reads 0x40 -> dbg_gnt once, mem_we=1 that cycle only, then cpu_rdata=0xDEADBEEF one cycle after cpu_gnt.
- CPU_PRIO=1, STARVE_LIMIT=4, both requesting continuously for 10 cycles -> grant pattern C,C,C,C,D,C,C,C,C,D; never two gnts high in one cycle.
- Debug read of 0x10 with dbg_lock=1, then dbg_req low for 3 cycles while cpu_req high, then dbg_lock=0 -> locked=1 after the first dbg grant; cpu_gnt=0 during the 3 cycles; cpu_gnt=1 in the cycle after dbg_lock falls.
- Both requesting a write, reset_n pulled low mid-cycle -> gnts and mem_we drop immediately; all rvalid, rdata, locked and counter read 0 after release; memory location unchanged.
- Core read grant at cycle N immediately followed by debug read at N+1 -> cpu_rvalid at N+1 and dbg_rvalid at N+2, each with its own address's data; neither rdata is overwritten.
